vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; UPSCALE 5 screen pixels per sprite pixel; TILE 8 sprite pixels per tile; SYNC_POL 0, active sync level.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 tick  in  1  pixel-clock enable; all counters advance only on clk edges where tick=1.
REQ-006 counter_H  out  10  horizontal pixel position, 0..799.
REQ-007 counter_V  out  10  vertical line position, 0..524.
REQ-008 hsync, vsync  out  1 each  sync pulses at level SYNC_POL.
REQ-009 display_on  out  1  high when counter_H<640 and counter_V<480.
REQ-010 tile_H  out  4 (0..15), tile_V  out  4 (0..11)  current tile column/row.
REQ-011 pix_col, pix_row  out  3 each  sprite pixel column/row inside the tile (0..7).
REQ-012 up_H, up_V  out  3 each  upscale phase inside the sprite pixel (0..4).
REQ-013 line_start  out  1  one-tick pulse with counter_H=0; frame_start  out  1  one-tick pulse with counter_H=0, counter_V=0.

Function
REQ-014 On each tick, counter_H increments and wraps 799->0; at that wrap counter_V increments and wraps 524->0.
REQ-015 With tick=0, every output holds its value, pulses included.
REQ-016 All outputs are registered and mutually aligned: every output describes the same (counter_H, counter_V) in the same cycle, with zero cycles of skew.
REQ-017 hsync = SYNC_POL for counter_H 656..751 inclusive, otherwise ~SYNC_POL; vsync = SYNC_POL for counter_V 490..491, otherwise ~SYNC_POL.
REQ-018 Horizontal decomposition uses incremental counters (no divider or multiplier): up_H wraps 4->0 and carries to pix_col; pix_col wraps 7->0 and carries to tile_H.
REQ-019 For counter_H<640, counter_H = 40*tile_H + 5*pix_col + up_H holds exactly; for counter_H>=640, tile_H, pix_col and up_H are all 0.
REQ-020 Vertical decomposition chains up_V -> pix_row -> tile_V, advancing once per line at the H wrap.
REQ-021 For counter_V<480, counter_V = 40*tile_V + 5*pix_row + up_V holds exactly; for counter_V>=480, tile_V, pix_row and up_V are all 0.
REQ-022 Boundary: at counter_H 639->640 the H fields clear to 0; at 799->0 they are already 0 and remain 0. The V fields behave the same way at 479->480 and 524->0.
REQ-023 Simultaneous end of line and end of frame (H 799, V 524) yields counter_H=0, counter_V=0 and frame_start=1 and line_start=1 in the same tick.
REQ-024 The H decomposition counters are 4/3/3 bits; no intermediate value exceeds its stated range.

Reset
REQ-025 While reset=0 at a clk edge: counters and all decomposition fields are 0, display_on=1, line_start=1, frame_start=1, hsync=vsync=~SYNC_POL. tick is ignored during reset.
REQ-026 After reset is released, the first tick advances counter_H to 1. Reset asserted mid-frame returns every output to the REQ-025 values on the next edge.

Structure
REQ-027 The shared package holds the timing constants (H/V active, porch and sync widths, totals 800/525), UPSCALE, TILE, TILE_LEN_PIXEL=40, and the tile-grid limits 15 and 11.
REQ-028 One sub-module, axis_decomp, is instantiated twice (H and V). Each instance has an advance enable, an active-region flag and a clear input, and outputs the tile/pix/up fields.

Verification
REQ-029 Scenario 1: release reset, tick=1 continuously for 800*525 ticks -> exactly one frame_start and 525 line_starts, with counter_H wrapping at 799.
REQ-030 Scenario 2: check sync widths -> hsync=SYNC_POL for exactly 96 ticks starting at counter_H=656; vsync=SYNC_POL for exactly 2 lines starting at counter_V=490.
REQ-031 Scenario 3: a scoreboard checks every active pixel against REQ-019/021. Example: counter_H=213 -> tile_H=5, pix_col=2, up_H=3; counter_V=479 -> tile_V=11, pix_row=7, up_V=4.
REQ-032 Scenario 4: tick toggling in a random pattern (about 50%) -> outputs change only in cycles where tick=1, and the sequence matches the continuous-tick run.
REQ-033 Scenario 5: assert reset at counter_H=400, counter_V=300 -> next edge gives all outputs at REQ-025 values; after release, counting restarts from 0,0.
REQ-034 Scenario 6: at H=799, V=524 apply one tick -> counter_H=0, counter_V=0, frame_start=1, line_start=1 and display_on=1 in the same cycle.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, field widths and the per-axis decomposition record
// used by the VGA timing generator and its axis decomposition counters.
package vga_timing_gen_pkg;

  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;  // 800

  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 33;
  localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;  // 525

  localparam int C_UPSCALE        = 5;
  localparam int C_TILE           = 8;
  localparam int C_TILE_LEN_PIXEL = C_UPSCALE * C_TILE;  // 40
  localparam int C_TILE_H_MAX     = 15;
  localparam int C_TILE_V_MAX     = 11;

  localparam int C_CNT_W  = 10;
  localparam int C_TILE_W = 4;
  localparam int C_PIX_W  = 3;
  localparam int C_UP_W   = 3;

  typedef struct packed {
    logic [C_TILE_W-1:0] tile;
    logic [C_PIX_W-1:0]  pix;
    logic [C_UP_W-1:0]   up;
  } axis_fields_t;

  function automatic logic in_window(input logic [C_CNT_W-1:0] pos,
                                     input logic [C_CNT_W-1:0] lo,
                                     input logic [C_CNT_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_decomp.sv
// One screen axis split into tile / sprite-pixel / upscale-phase fields using
// chained wrap counters, so no divider is needed to locate a pixel in the tile grid.
module axis_decomp
  import vga_timing_gen_pkg::*;
#(
  parameter int UPSCALE  = C_UPSCALE,
  parameter int TILE     = C_TILE,
  parameter int TILE_MAX = C_TILE_H_MAX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_adv,
  input  logic         i_active,
  input  logic         i_clr,
  output axis_fields_t o_fields
);

  localparam logic [C_UP_W-1:0]   L_UP_LAST   = C_UP_W'(UPSCALE - 1);
  localparam logic [C_PIX_W-1:0]  L_PIX_LAST  = C_PIX_W'(TILE - 1);
  localparam logic [C_TILE_W-1:0] L_TILE_LAST = C_TILE_W'(TILE_MAX);

  axis_fields_t r_fields;
  axis_fields_t w_next;

  // NOTE: w_next takes the current value first so every path assigns it and no latch is inferred.
  always_comb begin
    w_next = r_fields;
    if (r_fields.up == L_UP_LAST) begin
      w_next.up = '0;
      if (r_fields.pix == L_PIX_LAST) begin
        w_next.pix = '0;
        if (r_fields.tile != L_TILE_LAST) begin
          w_next.tile = r_fields.tile + C_TILE_W'(1);
        end
      end else begin
        w_next.pix = r_fields.pix + C_PIX_W'(1);
      end
    end else begin
      w_next.up = r_fields.up + C_UP_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignment; reset is synchronous and checked before any enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fields <= '0;
    end else if (i_clr) begin
      r_fields <= '0;
    end else if (i_adv && i_active) begin
      r_fields <= w_next;
    end
  end

  assign o_fields = r_fields;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync pulses and tile-grid coordinates,
// all registered from the same next position so every output lines up.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = C_H_ACTIVE,
  parameter int   H_FP     = C_H_FP,
  parameter int   H_SYNC   = C_H_SYNC,
  parameter int   H_BP     = C_H_BP,
  parameter int   V_ACTIVE = C_V_ACTIVE,
  parameter int   V_FP     = C_V_FP,
  parameter int   V_SYNC   = C_V_SYNC,
  parameter int   V_BP     = C_V_BP,
  parameter int   UPSCALE  = C_UPSCALE,
  parameter int   TILE     = C_TILE,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  output logic [C_CNT_W-1:0] counter_H,
  output logic [C_CNT_W-1:0] counter_V,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [C_TILE_W-1:0] tile_H,
  output logic [C_TILE_W-1:0] tile_V,
  output logic [C_PIX_W-1:0] pix_col,
  output logic [C_PIX_W-1:0] pix_row,
  output logic [C_UP_W-1:0]  up_H,
  output logic [C_UP_W-1:0]  up_V,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [C_CNT_W-1:0] L_H_LAST     = C_CNT_W'(H_TOTAL - 1);
  localparam logic [C_CNT_W-1:0] L_V_LAST     = C_CNT_W'(V_TOTAL - 1);
  localparam logic [C_CNT_W-1:0] L_H_ACTIVE   = C_CNT_W'(H_ACTIVE);
  localparam logic [C_CNT_W-1:0] L_V_ACTIVE   = C_CNT_W'(V_ACTIVE);
  localparam logic [C_CNT_W-1:0] L_H_ACT_LAST = C_CNT_W'(H_ACTIVE - 1);
  localparam logic [C_CNT_W-1:0] L_V_ACT_LAST = C_CNT_W'(V_ACTIVE - 1);
  localparam logic [C_CNT_W-1:0] L_HS_START   = C_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [C_CNT_W-1:0] L_HS_END     = C_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [C_CNT_W-1:0] L_VS_START   = C_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [C_CNT_W-1:0] L_VS_END     = C_CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [C_CNT_W-1:0] r_counter_H;
  logic [C_CNT_W-1:0] r_counter_V;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_display_on;
  logic               r_line_start;
  logic               r_frame_start;

  logic [C_CNT_W-1:0] w_next_H;
  logic [C_CNT_W-1:0] w_next_V;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_h_clr;
  logic               w_v_adv;
  logic               w_v_clr;
  logic               w_h_active;
  logic               w_v_active;
  axis_fields_t       w_h_fields;
  axis_fields_t       w_v_fields;

  assign w_h_wrap = (r_counter_H == L_H_LAST);
  assign w_v_wrap = (r_counter_V == L_V_LAST);

  always_comb begin
    w_next_H = w_h_wrap ? '0 : r_counter_H + C_CNT_W'(1);
    w_next_V = r_counter_V;
    if (w_h_wrap) begin
      w_next_V = w_v_wrap ? '0 : r_counter_V + C_CNT_W'(1);
    end
  end

  // Status outputs are computed from the next position so they land with the counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_counter_H   <= '0;
      r_counter_V   <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_display_on  <= 1'b1;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
    end else if (tick) begin
      r_counter_H   <= w_next_H;
      r_counter_V   <= w_next_V;
      r_hsync       <= in_window(w_next_H, L_HS_START, L_HS_END) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= in_window(w_next_V, L_VS_START, L_VS_END) ? SYNC_POL : ~SYNC_POL;
      r_display_on  <= (w_next_H < L_H_ACTIVE) && (w_next_V < L_V_ACTIVE);
      r_line_start  <= (w_next_H == '0);
      r_frame_start <= (w_next_H == '0) && (w_next_V == '0);
    end
  end

  // Fields clear when leaving the active region and simply hold 0 through blanking.
  assign w_h_active = (r_counter_H < L_H_ACTIVE);
  assign w_h_clr    = tick && (r_counter_H == L_H_ACT_LAST);
  assign w_v_active = (r_counter_V < L_V_ACTIVE);
  assign w_v_adv    = tick && w_h_wrap;
  assign w_v_clr    = w_v_adv && (r_counter_V == L_V_ACT_LAST);

  axis_decomp #(
    .UPSCALE  (UPSCALE),
    .TILE     (TILE),
    .TILE_MAX (C_TILE_H_MAX)
  ) u_h_decomp (
    .clk      (clk),
    .reset    (reset),
    .i_adv    (tick),
    .i_active (w_h_active),
    .i_clr    (w_h_clr),
    .o_fields (w_h_fields)
  );

  axis_decomp #(
    .UPSCALE  (UPSCALE),
    .TILE     (TILE),
    .TILE_MAX (C_TILE_V_MAX)
  ) u_v_decomp (
    .clk      (clk),
    .reset    (reset),
    .i_adv    (w_v_adv),
    .i_active (w_v_active),
    .i_clr    (w_v_clr),
    .o_fields (w_v_fields)
  );

  assign counter_H   = r_counter_H;
  assign counter_V   = r_counter_V;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign tile_H      = w_h_fields.tile;
  assign pix_col     = w_h_fields.pix;
  assign up_H        = w_h_fields.up;
  assign tile_V      = w_v_fields.tile;
  assign pix_row     = w_v_fields.pix;
  assign up_V        = w_v_fields.up;

endmodule
